// File: rtl/grf_pkg.sv
// Shared widths and the write-back entry layout used by the GRF write-port arbiter.
package grf_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0]  a3;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] pc;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending multi-cycle results, drained into idle GRF write cycles.
module wb_fifo
   import grf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  wb_entry_t              din,
   input  logic                   pop,
   output wb_entry_t              dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] cnt
);
   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == DEPTH[PTR_W:0]);
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the single GRF write port between W-stage writeback and buffered MD results,
// and keeps a pending-register scoreboard that stalls D on hazards with undrained results.
module grf_wport_arbiter
   import grf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   w_en,
   input  logic [REG_W-1:0]       w_a3,
   input  logic [DATA_W-1:0]      w_wd,
   input  logic [DATA_W-1:0]      w_pc,
   input  logic                   md_req,
   input  logic [REG_W-1:0]       md_a3,
   input  logic [DATA_W-1:0]      md_wd,
   input  logic [DATA_W-1:0]      md_pc,
   output logic                   md_ack,
   input  logic                   sb_set,
   input  logic [REG_W-1:0]       sb_a3,
   input  logic [REG_W-1:0]       d_a1,
   input  logic [REG_W-1:0]       d_a2,
   input  logic [REG_W-1:0]       d_a3,
   output logic                   stall,
   output logic                   grf_en,
   output logic [REG_W-1:0]       grf_a3,
   output logic [DATA_W-1:0]      grf_wd,
   output logic [DATA_W-1:0]      grf_pc,
   output logic [31:0]            pending,
   output logic [$clog2(DEPTH):0] fifo_cnt
);
   wb_entry_t   head;
   wb_entry_t   md_entry;
   logic        full;
   logic        empty;
   logic        w_own;
   logic        pop;
   logic        push;
   logic [31:0] pending_q;
   logic [31:0] pending_d;

   assign w_own    = w_en && (w_a3 != ZERO_REG);
   assign pop      = !w_own && !empty;
   assign md_ack   = reset && md_req && (!full || pop);
   // $0 results are acknowledged but never occupy a slot or a write cycle.
   assign push     = md_ack && (md_a3 != ZERO_REG);
   assign md_entry = '{a3: md_a3, wd: md_wd, pc: md_pc};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (md_entry),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .cnt   (fifo_cnt)
   );

   always_comb begin
      grf_en = w_en;
      grf_a3 = w_a3;
      grf_wd = w_wd;
      grf_pc = w_pc;
      if (pop) begin
         grf_en = 1'b1;
         grf_a3 = head.a3;
         grf_wd = head.wd;
         grf_pc = head.pc;
      end
   end

   // A reservation made in the same cycle as a drain to that register wins.
   always_comb begin
      pending_d = pending_q;
      if (pop) pending_d[head.a3] = 1'b0;
      if (sb_set && (sb_a3 != ZERO_REG)) pending_d[sb_a3] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pending = {pending_q[31:1], 1'b0};
   assign stall   = pending[d_a1] | pending[d_a2] | pending[d_a3];
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Random and directed stimulus checked against a queue-based model of the write-port arbiter.
module tb_grf_wport_arbiter;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        ack;
    logic        stall;
    logic        en;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic [31:0] pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w_en = 1'b0;
  logic [4:0]  w_a3 = '0;
  logic [31:0] w_wd = '0;
  logic [31:0] w_pc = '0;
  logic        md_req = 1'b0;
  logic [4:0]  md_a3 = '0;
  logic [31:0] md_wd = '0;
  logic [31:0] md_pc = '0;
  logic        md_ack;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_a3 = '0;
  logic [4:0]  d_a1 = '0;
  logic [4:0]  d_a2 = '0;
  logic [4:0]  d_a3 = '0;
  logic        stall;
  logic        grf_en;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] pending;
  logic [1:0]  fifo_cnt;

  int total = 0;
  int bad = 0;

  ent_t        mq[$];
  logic [31:0] mpend = '0;
  exp_t        exp_q[$];

  grf_wport_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .w_en(w_en), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
    .md_req(md_req), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc), .md_ack(md_ack),
    .sb_set(sb_set), .sb_a3(sb_a3),
    .d_a1(d_a1), .d_a2(d_a2), .d_a3(d_a3),
    .stall(stall),
    .grf_en(grf_en), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .pending(pending), .fifo_cnt(fifo_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, derive the expected outputs from the model, then advance the model.
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] wpc, input logic mr, input logic [4:0] ma, input logic [31:0] mwd,
                       input logic [31:0] mpc, input logic ss, input logic [4:0] sa,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3d);
    exp_t e;
    logic w_busy, drain, acc;
    ent_t h, n;
    @(posedge clk);
    #2;
    reset = rst; w_en = we; w_a3 = wa; w_wd = wd; w_pc = wpc;
    md_req = mr; md_a3 = ma; md_wd = mwd; md_pc = mpc;
    sb_set = ss; sb_a3 = sa; d_a1 = a1; d_a2 = a2; d_a3 = a3d;
    if (!rst) begin
      mq.delete();
      mpend = '0;
    end
    w_busy = we && (wa != 0);
    drain  = !w_busy && (mq.size() > 0);
    acc    = rst && mr && ((mq.size() < DEPTH) || drain);
    e.ack   = acc;
    e.stall = ((a1 != 0) && mpend[a1]) || ((a2 != 0) && mpend[a2]) || ((a3d != 0) && mpend[a3d]);
    e.cnt   = 2'(mq.size());
    e.pend  = mpend;
    if (drain) begin
      h = mq[0];
      e.en = 1'b1; e.a3 = h.a3; e.wd = h.wd; e.pc = h.pc;
    end else begin
      e.en = we; e.a3 = wa; e.wd = wd; e.pc = wpc;
    end
    exp_q.push_back(e);
    if (rst) begin
      if (drain) begin
        mpend[mq[0].a3] = 1'b0;
        void'(mq.pop_front());
      end
      if (acc && (ma != 0)) begin
        n.a3 = ma; n.wd = mwd; n.pc = mpc;
        mq.push_back(n);
      end
      if (ss && (sa != 0)) mpend[sa] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: one expected record per driven cycle, checked mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("md_ack", 32'(md_ack), 32'(e.ack));
      chk("stall", 32'(stall), 32'(e.stall));
      chk("grf_en", 32'(grf_en), 32'(e.en));
      chk("fifo_cnt", 32'(fifo_cnt), 32'(e.cnt));
      chk("pending", pending, e.pend);
      if (e.en) begin
        chk("grf_a3", 32'(grf_a3), 32'(e.a3));
        chk("grf_wd", grf_wd, e.wd);
        chk("grf_pc", grf_pc, e.pc);
      end
    end
  end

  // stimulus
  initial begin
    logic [4:0] pick[6];
    pick[0] = 5'd0; pick[1] = 5'd5; pick[2] = 5'd7; pick[3] = 5'd8; pick[4] = 5'd9; pick[5] = 5'd3;

    cycle(0, 1, 4, 32'h11, 32'h100, 1, 6, 32'h22, 32'h200, 1, 6, 6, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // mid-run reset with two buffered results and pending[5]
    cycle(1, 1, 3, 32'hA0, 32'h10, 1, 5, 32'h55, 32'h20, 1, 5, 0, 0, 0);
    cycle(1, 1, 3, 32'hA1, 32'h14, 1, 6, 32'h66, 32'h24, 1, 6, 5, 0, 0);
    cycle(1, 1, 3, 32'hA2, 32'h18, 0, 0, 0, 0, 0, 0, 5, 6, 0);
    cycle(0, 1, 3, 32'hA3, 32'h1C, 1, 7, 32'h77, 32'h28, 1, 7, 5, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 7);
    idle(2);

    // single MD result with idle W: one-cycle latency, then pending clears
    cycle(1, 0, 0, 0, 0, 1, 8, 32'h1234, 32'h300, 1, 8, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0);

    // W owns the port every cycle; third result waits until W goes idle
    cycle(1, 1, 3, 32'hB0, 32'h400, 1, 10, 32'hC0, 32'h500, 1, 10, 0, 0, 0);
    cycle(1, 1, 3, 32'hB1, 32'h404, 1, 11, 32'hC1, 32'h504, 1, 11, 0, 0, 0);
    cycle(1, 1, 3, 32'hB2, 32'h408, 1, 12, 32'hC2, 32'h508, 1, 12, 0, 0, 0);
    cycle(1, 1, 3, 32'hB3, 32'h40C, 1, 12, 32'hC2, 32'h508, 0, 0, 10, 11, 12);
    cycle(1, 0, 0, 0, 0, 1, 12, 32'hC2, 32'h508, 0, 0, 10, 11, 12);
    idle(4);

    // reservation on $9 stalls reads and writes of $9 until it drains
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    cycle(1, 1, 2, 32'hD0, 32'h600, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    cycle(1, 1, 2, 32'hD1, 32'h604, 1, 9, 32'h99, 32'h610, 0, 0, 0, 0, 9);
    cycle(1, 1, 2, 32'hD2, 32'h608, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 9);

    // result to $0 is acked and dropped; W to $0 passes through
    cycle(1, 1, 0, 32'hE0, 32'h700, 1, 0, 32'hEE, 32'h710, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 32'hEF, 32'h714, 0, 0, 0, 0, 0);
    idle(1);

    // reservation of $7 in the same cycle its older result drains
    cycle(1, 1, 4, 32'hF0, 32'h800, 1, 7, 32'h77, 32'h810, 1, 7, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 7, 32'h78, 32'h820, 0, 0, 0, 0, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic rst;
      logic [4:0] wa, ma, sa;
      rst = ($urandom_range(0, 199) != 0);
      wa  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : 5'($urandom_range(0, 31));
      ma  = pick[$urandom_range(0, 5)];
      sa  = ($urandom_range(0, 1) == 0) ? ma : 5'($urandom_range(0, 31));
      cycle(rst, ($urandom_range(0, 1) == 1), wa, $urandom, $urandom,
            ($urandom_range(0, 9) < 4), ma, $urandom, $urandom,
            ($urandom_range(0, 9) < 3), sa,
            pick[$urandom_range(0, 5)], 5'($urandom_range(0, 31)), pick[$urandom_range(0, 5)]);
    end
    idle(4);

    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
